// File: rtl/phy_striped_serializer.sv
// ---------------------------------------------------------------------------
// phy_striped_serializer
//
// Stripes parallel words across 1, 2 or 4 serial lanes at bit rate. After
// reset every lane sends SYNC_BYTES COM bytes (8'hBC, MSB first). It then
// idles on COM and accepts a word only at a byte boundary. A word is
// registered, split so that lane k carries bytes k, k+LANES, ..., and sent
// MSB first. Back-to-back words are sent with no gap between them.
//
// Optional feature (macro PHY_SCRAMBLE_EN): each lane has its own scrambler,
// x^16+x^5+x^4+x^3+1 seeded 16'hFFFF. The scrambler is applied to data bits
// only. COM bytes pass through untouched.
//
// Ports
//   clk_32f     in   bit-rate clock, all logic on its rising edge
//   reset       in   synchronous, active-high reset
//   data_in     in   [DATA_W] parallel word, byte j = data_in[8j+7:8j]
//   valid_in    in   data_in holds a word to send
//   ready_out   out  word accepted on a cycle with valid_in && ready_out
//   serial_out  out  [LANES] one registered serial bit per lane
//   active_out  out  registered, high while serial_out carries data bits
// ---------------------------------------------------------------------------
module phy_striped_serializer #(
  parameter int DATA_W     = 32,
  parameter int LANES      = 1,
  parameter int SYNC_BYTES = 2
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [LANES-1:0]  serial_out,
  output logic              active_out
);

  localparam int BYTES  = DATA_W / (8 * LANES);
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SYNC_W = (SYNC_BYTES > 1) ? $clog2(SYNC_BYTES) : 1;
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [7:0] COM = 8'hBC;

  typedef enum logic [1:0] {SYNC, IDLE, DATA} state_t;

  state_t              state, nxt_state;
  logic [2:0]          bit_cnt, nxt_bit;
  logic [BYTE_W-1:0]   byte_cnt, nxt_byte;
  logic [SYNC_W-1:0]   sync_cnt, nxt_sync;
  // The registers hold the bit that is currently on serial_out. 'started' is
  // low for the first cycle after reset: serial_out is still 0 then, so the
  // first edge must emit COM bit 7 without advancing the counters.
  logic                started;
  logic [DATA_W-1:0]   data_reg;
  logic [DATA_W-1:0]   word;
  logic                last_byte, accept;
  logic [LANES-1:0]    raw_bit, data_bit, serial_d;

  assign last_byte = (byte_cnt == BYTE_W'(BYTES - 1));
  // ready_out is decoded from registered state only, so it has no
  // combinational path from valid_in.
  assign ready_out = (bit_cnt == 3'd7) &&
                     ((state == IDLE) || ((state == DATA) && last_byte));
  assign accept    = valid_in && ready_out;

  // NOTE: every signal in an always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt_state = state;
    nxt_bit   = bit_cnt;
    nxt_byte  = byte_cnt;
    nxt_sync  = sync_cnt;
    if (started) begin
      if (bit_cnt == 3'd7) begin
        nxt_bit = 3'd0;
        unique case (state)
          SYNC: begin
            if (sync_cnt == SYNC_W'(SYNC_BYTES - 1)) begin
              nxt_state = IDLE;
              nxt_sync  = '0;
            end else begin
              nxt_sync = sync_cnt + SYNC_W'(1);
            end
          end
          IDLE: begin
            if (accept) begin
              nxt_state = DATA;
              nxt_byte  = '0;
            end
          end
          DATA: begin
            if (!last_byte) begin
              nxt_byte = byte_cnt + BYTE_W'(1);
            end else begin
              nxt_byte = '0;
              if (!accept) nxt_state = IDLE;
            end
          end
          default: nxt_state = SYNC;
        endcase
      end else begin
        nxt_bit = bit_cnt + 3'd1;
      end
    end
  end

  // On the accepting edge the first bit comes straight from data_in. The
  // rest of the word comes from the captured copy.
  assign word = accept ? data_in : data_reg;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      raw_bit[k] = word[IDX_W'(8 * (int'(nxt_byte) * LANES + k) + 7 - int'(nxt_bit))];
    end
  end

`ifdef PHY_SCRAMBLE_EN
  logic [15:0] lfsr_q [LANES];
  logic [15:0] lfsr_d [LANES];

  // The LFSR advances only when a data bit is emitted, so COM bytes and
  // idle time leave every lane's scrambler state untouched.
  always_comb begin
    data_bit = raw_bit;
    for (int k = 0; k < LANES; k++) begin
      lfsr_d[k] = lfsr_q[k];
      if (nxt_state == DATA) begin
        data_bit[k] = raw_bit[k] ^ lfsr_q[k][15];
        lfsr_d[k]   = {lfsr_q[k][14:0],
                       lfsr_q[k][15] ^ lfsr_q[k][4] ^ lfsr_q[k][3] ^ lfsr_q[k][2]};
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    for (int k = 0; k < LANES; k++) begin
      if (reset) lfsr_q[k] <= 16'hFFFF;
      else       lfsr_q[k] <= lfsr_d[k];
    end
  end
`else
  assign data_bit = raw_bit;
`endif

  assign serial_d = (nxt_state == DATA) ? data_bit : {LANES{COM[3'd7 - nxt_bit]}};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state      <= SYNC;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      sync_cnt   <= '0;
      started    <= 1'b0;
      serial_out <= '0;
      active_out <= 1'b0;
    end else begin
      state      <= nxt_state;
      bit_cnt    <= nxt_bit;
      byte_cnt   <= nxt_byte;
      sync_cnt   <= nxt_sync;
      started    <= 1'b1;
      serial_out <= serial_d;
      active_out <= (nxt_state == DATA);
    end
  end

  // NOTE: the word store is deliberately not reset. It is only read after an
  // acceptance has written it, so a reset would add fan-out and change nothing.
  always_ff @(posedge clk_32f) begin
    if (accept) data_reg <= data_in;
  end

endmodule

// File: tb/tb_phy_striped_serializer.sv
// ---------------------------------------------------------------------------
// tb_phy_striped_serializer
//
// Three serializers (LANES = 1, 2, 4; DATA_W = 32; SYNC_BYTES = 2) share one
// clock and reset. Each has its own data_in/valid_in. A stream-level model
// predicts serial_out, active_out and ready_out for every cycle. The model
// queues whole chunks of line symbols: the sync preamble, one COM byte, or
// one striped word. It chooses the next chunk when the previous one ends,
// using the valid_in value seen at that boundary. Directed steps come first,
// then a randomized phase. With PHY_SCRAMBLE_EN defined, the model scrambles
// data symbols as it queues them.
// ---------------------------------------------------------------------------
module tb_phy_striped_serializer;

  localparam int DW = 32;
  localparam int SB = 2;
  localparam logic [7:0] COM = 8'hBC;

  typedef struct {
    logic [3:0] bits;
    logic       act;
  } sym_t;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic [31:0] data_in  [3];
  logic        valid_in [3];
  logic        rdy      [3];
  logic        act      [3];
  logic [0:0]  s1;
  logic [1:0]  s2;
  logic [3:0]  s4;

  always #5 clk_32f = ~clk_32f;

  phy_striped_serializer #(.DATA_W(DW), .LANES(1), .SYNC_BYTES(SB)) u_l1 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in[0]), .valid_in(valid_in[0]),
    .ready_out(rdy[0]), .serial_out(s1), .active_out(act[0]));
  phy_striped_serializer #(.DATA_W(DW), .LANES(2), .SYNC_BYTES(SB)) u_l2 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in[1]), .valid_in(valid_in[1]),
    .ready_out(rdy[1]), .serial_out(s2), .active_out(act[1]));
  phy_striped_serializer #(.DATA_W(DW), .LANES(4), .SYNC_BYTES(SB)) u_l4 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in[2]), .valid_in(valid_in[2]),
    .ready_out(rdy[2]), .serial_out(s4), .active_out(act[2]));

  int checks   = 0;
  int failures = 0;

  // Model state per instance.
  sym_t        sbuf  [3][64];
  int          pos   [3];
  int          len   [3];
  bit          fresh [3];
  bit          acc   [3];
  logic [15:0] mlfsr [3][4];
  bit          armed = 1'b0;

  task automatic check(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  function automatic logic [3:0] serial_of(input int i);
    case (i)
      0:       return {3'b000, s1};
      1:       return {2'b00, s2};
      default: return s4;
    endcase
  endfunction

  task automatic push_com(input int i);
    for (int b = 0; b < 8; b++) begin
      sbuf[i][len[i]] = '{bits: {4{COM[7 - b]}} & 4'((1 << (1 << i)) - 1), act: 1'b0};
      len[i]++;
    end
  endtask

  task automatic push_word(input int i, input logic [31:0] w);
    int   lanes;
    logic b;
    lanes = 1 << i;
    for (int c = 0; c < DW / lanes; c++) begin
      sym_t s;
      s.bits = 4'b0000;
      s.act  = 1'b1;
      for (int k = 0; k < lanes; k++) begin
        b = w[8 * ((c / 8) * lanes + k) + 7 - (c % 8)];
`ifdef PHY_SCRAMBLE_EN
        b = b ^ mlfsr[i][k][15];
        mlfsr[i][k] = {mlfsr[i][k][14:0], ^(mlfsr[i][k] & 16'h801C)};
`endif
        s.bits[k] = b;
      end
      sbuf[i][len[i]] = s;
      len[i]++;
    end
  endtask

  // One clock cycle: check ready before the edge, advance the model at the
  // edge, and check the registered outputs 1 time unit after it.
  task automatic step();
    logic        v [3];
    logic [31:0] d [3];
    logic        r;
    sym_t        e [3];
    for (int i = 0; i < 3; i++) begin
      if (armed) check("ready_out", i, 32'(rdy[i]), 32'((pos[i] == len[i]) && !fresh[i]));
      v[i] = valid_in[i];
      d[i] = data_in[i];
    end
    r = reset;
    @(posedge clk_32f);
    for (int i = 0; i < 3; i++) begin
      acc[i] = 1'b0;
      if (r) begin
        pos[i] = 0;
        len[i] = 0;
        fresh[i] = 1'b1;
        for (int k = 0; k < 4; k++) mlfsr[i][k] = 16'hFFFF;
        e[i] = '{bits: 4'b0000, act: 1'b0};
      end else begin
        if (pos[i] == len[i]) begin
          pos[i] = 0;
          len[i] = 0;
          if (fresh[i]) begin
            // The sync preamble plus the one idle COM byte that always follows it.
            for (int n = 0; n <= SB; n++) push_com(i);
            fresh[i] = 1'b0;
          end else if (v[i]) begin
            acc[i] = 1'b1;
            push_word(i, d[i]);
          end else begin
            push_com(i);
          end
        end
        e[i] = sbuf[i][pos[i]];
        pos[i]++;
      end
    end
    if (r) armed = 1'b1;
    #1;
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        check("serial_out", i, 32'(serial_of(i)), 32'(e[i].bits));
        check("active_out", i, 32'(act[i]), 32'(e[i].act));
      end
    end
  endtask

  task automatic run_until_accept(input int i, output int n);
    n = 0;
    for (int t = 0; t < 48; t++) begin
      step();
      n++;
      if (acc[i]) break;
    end
    check("accept_seen", i, 32'(acc[i]), 32'd1);
  endtask

  initial begin
    logic [31:0] cap;
    int          n;
    int          act_cnt;

    for (int i = 0; i < 3; i++) begin
      valid_in[i] = 1'b0;
      data_in[i]  = '0;
      pos[i] = 0;
      len[i] = 0;
      fresh[i] = 1'b1;
    end

    // Reset for 2 cycles, then the full sync sequence on every lane.
    reset = 1'b1;
    step();
    step();
    check("reset_serial", 0, 32'(s1), 32'd0);
    check("reset_ready", 0, 32'(rdy[0]), 32'd0);
    reset = 1'b0;
    cap = '0;
    for (int c = 0; c < 16; c++) begin
      step();
      cap = {cap[30:0], s1};
    end
    check("sync_pattern", 0, cap, 32'h0000_BCBC);
    for (int c = 0; c < 24; c++) step();

    // One word on the single-lane instance, followed by COM.
    data_in[0] = 32'hA5C3_0F01;
    valid_in[0] = 1'b1;
    run_until_accept(0, n);
    valid_in[0] = 1'b0;
    data_in[0] = 32'hDEAD_BEEF;  // must not disturb the word in flight
    cap = {31'd0, s1};
    act_cnt = int'(act[0]);
    for (int c = 1; c < 40; c++) begin
      step();
      if (c < 32) cap = {cap[30:0], s1};
      act_cnt += int'(act[0]);
    end
    check("word_l1", 0, cap, 32'h010F_C3A5);
    check("active_len", 0, 32'(act_cnt), 32'd32);

    // Four lanes send the four bytes in parallel.
    data_in[2] = 32'h4433_2211;
    valid_in[2] = 1'b1;
    run_until_accept(2, n);
    valid_in[2] = 1'b0;
    cap = '0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) cap[8 * k + 7 - c] = s4[k];
      if (c < 7) step();
    end
    check("word_l4", 2, cap, 32'h4433_2211);
    for (int c = 0; c < 12; c++) step();

    // Two lanes, back-to-back words: the second is accepted exactly 16 cycles later.
    data_in[1] = 32'h0000_0000;
    valid_in[1] = 1'b1;
    run_until_accept(1, n);
    data_in[1] = 32'hFFFF_FFFF;
    run_until_accept(1, n);
    check("b2b_spacing", 1, 32'(n), 32'd16);
    valid_in[1] = 1'b0;
    for (int c = 0; c < 24; c++) step();

    // Reset while bit 10 of a single-lane word is on the line.
    data_in[0] = 32'h1234_5678;
    valid_in[0] = 1'b1;
    run_until_accept(0, n);
    valid_in[0] = 1'b0;
    for (int c = 0; c < 10; c++) step();
    reset = 1'b1;
    step();
    check("abort_serial", 0, 32'(s1), 32'd0);
    check("abort_active", 0, 32'(act[0]), 32'd0);
    reset = 1'b0;
    cap = '0;
    for (int c = 0; c < 16; c++) begin
      step();
      cap = {cap[30:0], s1};
    end
    check("resync_pattern", 0, cap, 32'h0000_BCBC);

    // Randomized traffic with occasional resets, checked against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        data_in[i]  = $urandom;
        valid_in[i] = ($urandom_range(0, 3) != 0);
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
